// File: rtl/cv32e41s_pmp_imp_responder.sv
// ----------------------------------------------------------------------------
// cv32e41s_pmp_imp_responder
//
// Responder end of the PMP-trie implicit-access interface. A single-cycle
// fetch request from the xpmp is turned into two 32-bit OBI reads on a
// dedicated master port: word b0 at the 8-byte aligned node address and
// word b1 at address+4. When both responses are back, both words are
// returned to the requester in one rvalid pulse.
//
// Handshakes:
//   pmp_imp side : pmp_imp_req_i is a one-cycle strobe, only honoured in IDLE.
//                  pmp_imp_rvalid_o is a one-cycle strobe; pmp_imp_err_o and
//                  both rdata outputs are meaningful while it is high.
//   OBI side     : an address phase completes on a cycle where obi_req_o and
//                  obi_gnt_i are both high; obi_req_o/obi_addr_o never change
//                  while waiting for grant. Every obi_rvalid_i completes the
//                  oldest outstanding read (in-order responses).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pmp_imp_req_i         fetch request strobe
//   pmp_imp_addr_i        node address (bits [2:0] ignored)
//   pmp_imp_flush_i       abort the fetch in progress
//   pmp_imp_rvalid_o      response strobe
//   pmp_imp_rdata_b0_o    word at aligned address
//   pmp_imp_rdata_b1_o    word at aligned address + 4
//   pmp_imp_err_o         an OBI error occurred on either word
//   pmp_imp_busy_o        high whenever the FSM is not IDLE
//   obi_*                 OBI read master (we=0, be=4'hF, prot=OBI_PROT)
// ----------------------------------------------------------------------------
module cv32e41s_pmp_imp_responder #(
    parameter bit         PIPELINED = 1'b1,
    parameter logic [2:0] OBI_PROT  = 3'b111
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        pmp_imp_req_i,
    input  logic [31:0] pmp_imp_addr_i,
    input  logic        pmp_imp_flush_i,
    output logic        pmp_imp_rvalid_o,
    output logic [31:0] pmp_imp_rdata_b0_o,
    output logic [31:0] pmp_imp_rdata_b1_o,
    output logic        pmp_imp_err_o,
    output logic        pmp_imp_busy_o,

    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [2:0]  obi_prot_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        DRAIN = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [28:0] base_q, base_d;      // node address [31:3]
    logic [1:0]  issued_q, issued_d;  // address phases granted this fetch
    logic [1:0]  rcvd_q, rcvd_d;      // responses received this fetch
    logic        err_q, err_d;        // sticky OBI error
    logic        flush_q, flush_d;    // flush seen while a request awaits grant
    logic [31:0] b0_q, b0_d;
    logic [31:0] b1_q, b1_d;

    logic        gnt_fire;
    logic        flush_pend;
    logic [31:0] rsp_word;

    // The low address bits are forced to zero; they are intentionally unused.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^pmp_imp_addr_i[2:0];

    // OBI address phase is a pure function of state so it is stable until grant.
    // base+4 only sets bit 2, so it can never carry into the upper bits.
    assign obi_req_o  = (state_q == REQ0) || (state_q == REQ1);
    assign obi_addr_o = (state_q == REQ0) ? {base_q, 3'b000} :
                        (state_q == REQ1) ? {base_q, 3'b100} : 32'h0;
    assign obi_we_o   = 1'b0;
    assign obi_be_o   = 4'hF;
    assign obi_prot_o = OBI_PROT;

    assign gnt_fire   = obi_req_o && obi_gnt_i;
    // A flush cannot retract a raised request, so it is remembered until grant.
    assign flush_pend = flush_q || pmp_imp_flush_i;
    // An erroring response stores zero in place of the bus data.
    assign rsp_word   = obi_err_i ? 32'h0 : obi_rdata_i;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        issued_d = issued_q + {1'b0, gnt_fire};
        rcvd_d   = rcvd_q + {1'b0, obi_rvalid_i};
        err_d    = err_q | (obi_rvalid_i & obi_err_i);
        flush_d  = flush_q;
        b0_d     = b0_q;
        b1_d     = b1_q;

        // Responses arrive in order: first one is b0, second one is b1.
        if (obi_rvalid_i) begin
            if (rcvd_q == 2'd0) begin
                b0_d = rsp_word;
            end else begin
                b1_d = rsp_word;
            end
        end

        case (state_q)
            IDLE: begin
                if (pmp_imp_req_i) begin
                    base_d   = pmp_imp_addr_i[31:3];
                    issued_d = 2'd0;
                    rcvd_d   = 2'd0;
                    err_d    = 1'b0;
                    flush_d  = 1'b0;
                    state_d  = REQ0;
                end
            end
            REQ0: begin
                flush_d = flush_pend;
                if (gnt_fire) begin
                    if (flush_pend) begin
                        state_d = DRAIN;
                    end else if (PIPELINED) begin
                        state_d = REQ1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            REQ1: begin
                flush_d = flush_pend;
                if (gnt_fire) begin
                    state_d = flush_pend ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (pmp_imp_flush_i) begin
                    state_d = DRAIN;
                end else if (rcvd_d == 2'd2) begin
                    state_d = RESP;
                end else if ((issued_q == 2'd1) && (rcvd_d == 2'd1)) begin
                    // Non-pipelined: first word is back, issue the second read.
                    state_d = REQ1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                // A response arriving with the flush is already in rcvd_d.
                if (rcvd_d == issued_d) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
            b0_q     <= '0;
            b1_q     <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            err_q    <= err_d;
            flush_q  <= flush_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
        end
    end

    assign pmp_imp_rvalid_o   = (state_q == RESP);
    assign pmp_imp_err_o      = (state_q == RESP) && err_q;
    assign pmp_imp_busy_o     = (state_q != IDLE);
    assign pmp_imp_rdata_b0_o = b0_q;
    assign pmp_imp_rdata_b1_o = b1_q;

endmodule

// File: tb/tb_cv32e41s_pmp_imp_responder.sv
// ----------------------------------------------------------------------------
// Bench for cv32e41s_pmp_imp_responder. Two instances: index 0 is
// PIPELINED=1, index 1 is PIPELINED=0. Each has its own OBI slave model
// (programmable grant delay, response delay and error address; memory word
// at address a is a ^ 32'h5A5A5A5A). Expected responses are pushed by the
// driver as {inst, err, b0, b1, expected rvalid cycle (0 = any)} and popped
// by an independent monitor whenever a DUT raises pmp_imp_rvalid_o.
// ----------------------------------------------------------------------------
module tb_cv32e41s_pmp_imp_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- DUT-facing signals ----------------
    logic        req_i   [2];
    logic [31:0] addr_i  [2];
    logic        flush_i [2];
    logic        rvalid_o[2];
    logic [31:0] b0_o    [2];
    logic [31:0] b1_o    [2];
    logic        err_o   [2];
    logic        busy_o  [2];
    logic        oreq_o  [2];
    logic [31:0] oaddr_o [2];
    logic        owe_o   [2];
    logic [3:0]  obe_o   [2];
    logic [2:0]  oprot_o [2];

    // bus model controls and logs
    int          gnt_dly [2];
    int          rsp_dly [2];
    logic [31:0] err_addr[2];
    logic [31:0] glog    [2][8];
    int          gcnt    [2];
    int          n_rsp   [2];

    // ---------------- scoreboard ----------------
    logic [97:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DUTs and OBI slave models ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit PIPE = (g == 0);

        logic        gnt;
        logic        rvalid;
        logic        rerr;
        logic [31:0] rdata;
        logic [63:0] pend_q[$];   // {addr, due cycle}
        int          wcnt;
        int          last_due;
        logic [31:0] last_addr;

        cv32e41s_pmp_imp_responder #(
            .PIPELINED (PIPE),
            .OBI_PROT  (3'b111)
        ) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .pmp_imp_req_i      (req_i[g]),
            .pmp_imp_addr_i     (addr_i[g]),
            .pmp_imp_flush_i    (flush_i[g]),
            .pmp_imp_rvalid_o   (rvalid_o[g]),
            .pmp_imp_rdata_b0_o (b0_o[g]),
            .pmp_imp_rdata_b1_o (b1_o[g]),
            .pmp_imp_err_o      (err_o[g]),
            .pmp_imp_busy_o     (busy_o[g]),
            .obi_req_o          (oreq_o[g]),
            .obi_gnt_i          (gnt),
            .obi_addr_o         (oaddr_o[g]),
            .obi_we_o           (owe_o[g]),
            .obi_be_o           (obe_o[g]),
            .obi_prot_o         (oprot_o[g]),
            .obi_rvalid_i       (rvalid),
            .obi_rdata_i        (rdata),
            .obi_err_i          (rerr)
        );

        initial begin
            gnt = 1'b0; rvalid = 1'b0; rerr = 1'b0; rdata = 32'h0;
            wcnt = 0; last_due = 0; last_addr = 32'h0;
        end

        // Slave drives for the coming posedge from the stable negedge view.
        always @(negedge clk) begin
            logic [63:0] e;
            int          due;
            if (!rst_n) begin
                pend_q.delete();
                gnt = 1'b0; rvalid = 1'b0; rerr = 1'b0; rdata = 32'h0;
                wcnt = 0; last_due = 0;
            end else begin
                rvalid = 1'b0; rerr = 1'b0; rdata = 32'h0;
                if (pend_q.size() != 0 && int'(pend_q[0][31:0]) <= cyc) begin
                    e      = pend_q.pop_front();
                    rvalid = 1'b1;
                    rerr   = (e[63:32] == err_addr[g]);
                    rdata  = rerr ? 32'hDEAD_BEEF : (e[63:32] ^ 32'h5A5A_5A5A);
                    n_rsp[g]++;
                end
                gnt = 1'b0;
                if (oreq_o[g]) begin
                    // pipelined: at most one already outstanding; non-pipelined: none
                    check("outstanding_bound", 128'(pend_q.size() <= ((g == 0) ? 1 : 0)), 128'(1));
                    if (wcnt > 0) check("obi_addr_stable", 128'(oaddr_o[g]), 128'(last_addr));
                    last_addr = oaddr_o[g];
                    if (wcnt >= gnt_dly[g]) begin
                        gnt  = 1'b1;
                        wcnt = 0;
                        if (gcnt[g] < 8) glog[g][gcnt[g]] = oaddr_o[g];
                        gcnt[g]++;
                        due = cyc + rsp_dly[g];
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        pend_q.push_back({oaddr_o[g], 32'(due)});
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end

        // The requester must never strobe while the responder is busy.
        always @(negedge clk) begin
            #2;
            if (rst_n && req_i[g] && busy_o[g]) begin
                n_fail++;
                $display("[TB] FAIL req_while_busy: inst %0d got req with busy=1, required busy=0", g);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [97:0] e;
        for (int g = 0; g < 2; g++) begin
            if (rst_n && rvalid_o[g]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rvalid: inst %0d got rvalid at cycle %0d, required none", g, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_inst", 128'(g), 128'(e[97]));
                    check("rsp_err_b0_b1", {63'h0, err_o[g], b0_o[g], b1_o[g]}, {63'h0, e[96:32]});
                    if (e[31:0] != 32'h0) check("rsp_cycle", 128'(cyc), 128'(e[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Strobe a request in cycle T and queue the expected response at T+lat.
    task automatic fetch(input int g, input logic [31:0] a, input logic e_err,
                         input logic [31:0] e_b0, input logic [31:0] e_b1, input int lat);
        @(negedge clk);
        exp_q.push_back({1'(g), e_err, e_b0, e_b1, (lat == 0) ? 32'h0 : 32'(cyc + lat)});
        req_i[g]  = 1'b1;
        addr_i[g] = a;
        @(negedge clk);
        req_i[g]  = 1'b0;
        addr_i[g] = 32'h0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        logic done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy_o[g] && exp_q.size() == 0) done = 1'b1;
        end
        check("idle_within_budget", 128'(done), 128'(1));
    endtask

    task automatic check_reset_outs(input int g);
        check("rst_pmp_side", {62'h0, rvalid_o[g], err_o[g], busy_o[g], b0_o[g], b1_o[g]}, 128'h0);
        check("rst_obi_req_addr", {95'h0, oreq_o[g], oaddr_o[g]}, 128'h0);
        check("rst_obi_we_be_prot", {120'h0, owe_o[g], obe_o[g], oprot_o[g]}, {120'h0, 1'b0, 4'hF, 3'b111});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int rsp0;
        for (int g = 0; g < 2; g++) begin
            req_i[g] = 1'b0; addr_i[g] = 32'h0; flush_i[g] = 1'b0;
            gnt_dly[g] = 0; rsp_dly[g] = 1; err_addr[g] = 32'h1;
            gcnt[g] = 0; n_rsp[g] = 0;
        end

        repeat (3) @(negedge clk);
        check_reset_outs(0);
        check_reset_outs(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait, pipelined: unaligned address is forced to 0x1000.
        gcnt[0] = 0;
        fetch(0, 32'h0000_1004, 1'b0, 32'h5A5A_4A5A, 32'h5A5A_4A5E, 4);
        wait_idle(0, 20);
        check("p1_gnt_count", 128'(gcnt[0]), 128'(2));
        check("p1_addr0", 128'(glog[0][0]), 128'h1000);
        check("p1_addr1", 128'(glog[0][1]), 128'h1004);

        // Zero-wait, non-pipelined: one extra cycle.
        fetch(1, 32'h0000_1000, 1'b0, 32'h5A5A_4A5A, 32'h5A5A_4A5E, 5);
        wait_idle(1, 20);

        // Non-pipelined, each grant delayed 3 cycles.
        gnt_dly[1] = 3;
        gcnt[1] = 0;
        fetch(1, 32'h0000_2000, 1'b0, 32'h5A5A_7A5A, 32'h5A5A_7A5E, 11);
        wait_idle(1, 40);
        check("p0_addr0", 128'(glog[1][0]), 128'h2000);
        check("p0_addr1", 128'(glog[1][1]), 128'h2004);
        gnt_dly[1] = 0;

        // Error on the second word: b1 stored as zero, err qualifies rvalid.
        err_addr[0] = 32'h0000_3004;
        fetch(0, 32'h0000_3000, 1'b1, 32'h5A5A_6A5A, 32'h0, 4);
        wait_idle(0, 20);
        err_addr[0] = 32'h1;

        // Flush one cycle after the first grant, responses 4 cycles late.
        rsp_dly[0] = 4;
        rsp0 = n_rsp[0];
        @(negedge clk);
        req_i[0] = 1'b1; addr_i[0] = 32'h0000_4000;   // cycle T
        @(negedge clk);
        req_i[0] = 1'b0; addr_i[0] = 32'h0;            // T+1: REQ0 granted
        @(negedge clk);
        flush_i[0] = 1'b1;                             // T+2: REQ1 granted
        @(negedge clk);
        flush_i[0] = 1'b0;                             // T+3
        repeat (3) @(negedge clk);                     // T+6: second response
        check("drain_busy_at_last_rsp", 128'(busy_o[0]), 128'(1));
        @(negedge clk);                                // T+7
        check("drain_busy_after", 128'(busy_o[0]), 128'(0));
        check("drain_rsp_count", 128'(n_rsp[0] - rsp0), 128'(2));
        rsp_dly[0] = 1;
        fetch(0, 32'h0000_5008, 1'b0, 32'h5A5A_0A52, 32'h5A5A_0A56, 4);
        wait_idle(0, 20);

        // Flush during RESP does not suppress the pulse.
        fetch(0, 32'h0000_8000, 1'b0, 32'h5A5A_DA5A, 32'h5A5A_DA5E, 4);
        repeat (2) @(negedge clk);                     // T+3
        @(negedge clk);                                // T+4: RESP
        flush_i[0] = 1'b1;
        @(negedge clk);
        flush_i[0] = 1'b0;
        wait_idle(0, 20);

        // Top of the address space: no wrap on +4.
        gcnt[0] = 0;
        fetch(0, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_A5A2, 32'hA5A5_A5A6, 4);
        wait_idle(0, 20);
        check("top_addr0", 128'(glog[0][0]), 128'hFFFF_FFF8);
        check("top_addr1", 128'(glog[0][1]), 128'hFFFF_FFFC);

        // Asynchronous reset while WAIT holds two outstanding reads.
        rsp_dly[0] = 5;
        @(negedge clk);
        req_i[0] = 1'b1; addr_i[0] = 32'h0000_6000;   // T
        @(negedge clk);
        req_i[0] = 1'b0; addr_i[0] = 32'h0;            // T+1
        repeat (2) @(negedge clk);                     // T+3: WAIT
        check("pre_reset_busy", 128'(busy_o[0]), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs(0);
        rsp_dly[0] = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(0, 32'h0000_7000, 1'b0, 32'h5A5A_2A5A, 32'h5A5A_2A5E, 4);
        wait_idle(0, 20);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog so the bench always ends.
    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e41s_pmp_imp_responder.md
Name: cv32e41s_pmp_imp_responder

Overview:
- Responder end of the PMP-trie implicit-access interface (pmp_imp_req / pmp_imp_addr / pmp_imp_rvalid / pmp_imp_rdata_b0 / pmp_imp_rdata_b1) driven by the xpmp in the MPU.
- Accepts a trie-node fetch request and issues two 32-bit OBI reads on a dedicated master port: word b0 at the aligned address, word b1 at address+4.
- Returns both words to the requester in a single-cycle rvalid pulse.
- Sits between the MPU/xpmp and the data-side bus arbiter.

Parameters:
- PIPELINED, 1, 1: issue the second OBI request right after the first grant (up to 2 outstanding); 0: issue it only after the first response.
- OBI_PROT, 3'b111, value driven on obi_prot_o (M-mode data access).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pmp_imp_req_i  in  1  single-cycle fetch request
- pmp_imp_addr_i  in  32  node address; bits [2:0] ignored (forced 0)
- pmp_imp_flush_i  in  1  abort the current fetch
- pmp_imp_rvalid_o  out  1  one-cycle pulse; both data words valid
- pmp_imp_rdata_b0_o  out  32  word at addr
- pmp_imp_rdata_b1_o  out  32  word at addr+4
- pmp_imp_err_o  out  1  qualifies rvalid; an OBI error occurred on either word
- pmp_imp_busy_o  out  1  high in every state except IDLE
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  OBI address
- obi_we_o  out  1  tied 0
- obi_be_o  out  4  tied 4'hF
- obi_prot_o  out  3  OBI_PROT
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI read data
- obi_err_i  in  1  OBI response error

Behaviour:
- Reset values:
  - All outputs 0, except obi_be_o = 4'hF and obi_prot_o = OBI_PROT.
  - State IDLE; rdata registers 0.
- FSM states: IDLE, REQ0, REQ1, WAIT, RESP, DRAIN.
- IDLE:
  - On pmp_imp_req_i, latch {addr[31:3], 3'b000}.
  - Clear the response counter and the sticky error bit.
  - Go to REQ0.
- REQ0:
  - obi_req_o=1, obi_addr_o=base.
  - On gnt: go to REQ1 if PIPELINED, otherwise WAIT, then REQ1 once the first response arrives.
- REQ1:
  - obi_req_o=1, obi_addr_o=base+4.
  - On gnt, go to WAIT.
- OBI rules:
  - obi_req_o and obi_addr_o stay stable until gnt (OBI rule).
  - No new request is raised in a cycle without a pending outstanding slot: at most 2 outstanding.
- Response routing:
  - OBI responses return in order.
  - First obi_rvalid_i: store rdata into b0. Second: store into b1.
  - obi_err_i ORs into the sticky error bit, and the corresponding word is stored as 0.
- Completion:
  - When both responses have been received, go to RESP.
  - In RESP: pmp_imp_rvalid_o=1 for exactly one cycle, pmp_imp_err_o=sticky error, data outputs hold the stored words. Then go to IDLE.
- Latency with zero-wait bus (gnt same cycle, rvalid next cycle), PIPELINED=1, request at cycle T:
  - obi_req at T+1 (addr) and T+2 (addr+4).
  - rvalid at T+2 and T+3.
  - pmp_imp_rvalid_o at T+4.
- Latency with PIPELINED=0: pmp_imp_rvalid_o at T+5.
- Back-to-back:
  - A request is accepted in the same cycle RESP is exited only if the state is IDLE, so the earliest next acceptance is the cycle after RESP.
  - pmp_imp_req_i while busy is ignored. The requester guarantees it does not issue one; a bench assertion checks this.
- Flush:
  - Flush in REQ0/REQ1 before gnt: drop obi_req_o next cycle. Exception: obi_req_o may not be retracted once raised (OBI), so the block completes the handshake for that request first.
  - Flush with any request outstanding: go to DRAIN, consume the remaining responses, return to IDLE with no rvalid pulse.
  - Flush in IDLE or RESP has no effect; the RESP pulse still completes.
- Flush and response in the same cycle: the response is counted toward the drain.
- Address arithmetic:
  - base+4 never carries out of bit 2, because base is 8-byte aligned.
  - 0xFFFFFFF8 fetches 0xFFFFFFF8 and 0xFFFFFFFC, with no wrap.
- Reset mid-operation: all state returns to IDLE asynchronously; the bus side is reset by the same rst_n.

Test Plan:
- Zero-wait bus, req with addr=0x0000_1004 → OBI reads at 0x1000 then 0x1004; b0=mem[0x1000], b1=mem[0x1004]; rvalid exactly at T+4; err=0.
- PIPELINED=0, gnt delayed 3 cycles on each request → second obi_req_o rises only after first rvalid; obi_addr_o stable while req high without gnt; single rvalid pulse.
- obi_err_i on second response → pmp_imp_err_o=1 with rvalid, b1=0, b0=correct data.
- Flush one cycle after first gnt, responses delayed 4 cycles → DRAIN consumes both responses, no rvalid, busy drops after second response, next req served normally.
- addr=0xFFFF_FFF8 → OBI addresses 0xFFFFFFF8 and 0xFFFFFFFC; correct data returned.
- Assert rst_n low while WAIT with 2 outstanding → all outputs at reset values immediately; busy=0; obi_req_o=0.
